// File: rtl/pipeline_hazard_regs_if.sv
// Signal bundle between the fetch side, StallDetection and the hazard
// register bank. The master modport belongs to whoever drives the fetched
// instruction and the stall requests. The slave modport belongs to the
// register bank, which returns PCwrite and the per-stage fields.
//
// Handshake semantics: there is no ready/back-pressure path on the
// instruction stream itself. IFvalid qualifies IFinstr in the same cycle.
// IDStall/EXStall are the only flow control. While either is high,
// PCwrite is low and the upstream registers hold their contents.
interface pipeline_hazard_regs_if;
    logic [31:0] IFinstr;
    logic        IFvalid;
    logic        flush;
    logic        IDStall;
    logic        EXStall;
    logic        PCwrite;
    logic [5:0]  IDop;
    logic [4:0]  IDrm;
    logic [4:0]  IDrn;
    logic [5:0]  EXop;
    logic [4:0]  EXrp;
    logic [4:0]  EXrm;
    logic [4:0]  EXrn;
    logic [5:0]  MEMop;
    logic [4:0]  MEMrn;

    modport master (
        output IFinstr, IFvalid, flush, IDStall, EXStall,
        input  PCwrite, IDop, IDrm, IDrn, EXop, EXrp, EXrm, EXrn, MEMop, MEMrn
    );

    modport slave (
        input  IFinstr, IFvalid, flush, IDStall, EXStall,
        output PCwrite, IDop, IDrm, IDrn, EXop, EXrp, EXrm, EXrn, MEMop, MEMrn
    );
endinterface

// File: rtl/pipeline_hazard_regs.sv
// Pipeline register bank for the ID, EX and MEM stages of a 5-stage CPU.
// It holds or bubbles stages on the IDStall/EXStall requests from
// StallDetection. EXStall (load-use) dominates IDStall (branch operand).
// A flush squashes the IF/ID entry only when no stall is active.
// An invalid stage drives BUBBLE_OP and zero register fields.
// Optional macro HAZARD_STALL_COUNT_EN adds two free-running stall counters.
module pipeline_hazard_regs #(
    parameter logic [5:0] BUBBLE_OP = 6'b111111
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_regs_if.slave  bus
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [31:0]            IDStallCount,
    output logic [31:0]            EXStallCount
`endif
);

    // IF/ID
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    // ID/EX
    logic [5:0]  idex_op_q, idex_op_d;
    logic [4:0]  idex_rs_q, idex_rs_d;
    logic [4:0]  idex_rt_q, idex_rt_d;
    logic [4:0]  idex_rd_q, idex_rd_d;
    logic        idex_valid_q, idex_valid_d;
    // EX/MEM
    logic [5:0]  exmem_op_q, exmem_op_d;
    logic [4:0]  exmem_rt_q, exmem_rt_d;
    logic        exmem_valid_q, exmem_valid_d;

    logic ex_stall;
    logic id_stall;

    // EXStall wins over IDStall.
    assign ex_stall = bus.EXStall;
    assign id_stall = bus.IDStall & ~bus.EXStall;

    // Next-state selection for the three stage registers
    always_comb begin
        ifid_instr_d  = ifid_instr_q;
        ifid_valid_d  = ifid_valid_q;
        idex_op_d     = idex_op_q;
        idex_rs_d     = idex_rs_q;
        idex_rt_d     = idex_rt_q;
        idex_rd_d     = idex_rd_q;
        idex_valid_d  = idex_valid_q;
        exmem_op_d    = exmem_op_q;
        exmem_rt_d    = exmem_rt_q;
        exmem_valid_d = exmem_valid_q;

        if (ex_stall) begin
            // Load-use: freeze IF/ID and ID/EX and send a bubble into MEM.
            exmem_op_d    = 6'd0;
            exmem_rt_d    = 5'd0;
            exmem_valid_d = 1'b0;
        end else if (id_stall) begin
            // Branch operand pending: freeze IF/ID, drain EX and put a bubble into EX.
            exmem_op_d    = idex_op_q;
            exmem_rt_d    = idex_rt_q;
            exmem_valid_d = idex_valid_q;
            idex_op_d     = 6'd0;
            idex_rs_d     = 5'd0;
            idex_rt_d     = 5'd0;
            idex_rd_d     = 5'd0;
            idex_valid_d  = 1'b0;
        end else begin
            exmem_op_d    = idex_op_q;
            exmem_rt_d    = idex_rt_q;
            exmem_valid_d = idex_valid_q;
            idex_op_d     = ifid_instr_q[31:26];
            idex_rs_d     = ifid_instr_q[25:21];
            idex_rt_d     = ifid_instr_q[20:16];
            idex_rd_d     = ifid_instr_q[15:11];
            idex_valid_d  = ifid_valid_q;
            if (bus.flush) begin
                ifid_instr_d = 32'd0;
                ifid_valid_d = 1'b0;
            end else begin
                ifid_instr_d = bus.IFinstr;
                ifid_valid_d = bus.IFvalid;
            end
        end
    end

    // Stage registers; reset empties every stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_instr_q  <= 32'd0;
            ifid_valid_q  <= 1'b0;
            idex_op_q     <= 6'd0;
            idex_rs_q     <= 5'd0;
            idex_rt_q     <= 5'd0;
            idex_rd_q     <= 5'd0;
            idex_valid_q  <= 1'b0;
            exmem_op_q    <= 6'd0;
            exmem_rt_q    <= 5'd0;
            exmem_valid_q <= 1'b0;
        end else begin
            ifid_instr_q  <= ifid_instr_d;
            ifid_valid_q  <= ifid_valid_d;
            idex_op_q     <= idex_op_d;
            idex_rs_q     <= idex_rs_d;
            idex_rt_q     <= idex_rt_d;
            idex_rd_q     <= idex_rd_d;
            idex_valid_q  <= idex_valid_d;
            exmem_op_q    <= exmem_op_d;
            exmem_rt_q    <= exmem_rt_d;
            exmem_valid_q <= exmem_valid_d;
        end
    end

    // Outputs come only from registers. Invalid stages show a bubble.
    always_comb begin
        bus.PCwrite = ~(bus.IDStall | bus.EXStall);
        bus.IDop    = ifid_valid_q  ? ifid_instr_q[31:26] : BUBBLE_OP;
        bus.IDrm    = ifid_valid_q  ? ifid_instr_q[25:21] : 5'd0;
        bus.IDrn    = ifid_valid_q  ? ifid_instr_q[20:16] : 5'd0;
        bus.EXop    = idex_valid_q  ? idex_op_q           : BUBBLE_OP;
        bus.EXrp    = idex_valid_q  ? idex_rd_q           : 5'd0;
        bus.EXrm    = idex_valid_q  ? idex_rs_q           : 5'd0;
        bus.EXrn    = idex_valid_q  ? idex_rt_q           : 5'd0;
        bus.MEMop   = exmem_valid_q ? exmem_op_q          : BUBBLE_OP;
        bus.MEMrn   = exmem_valid_q ? exmem_rt_q          : 5'd0;
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] id_cnt_q, id_cnt_d;
    logic [31:0] ex_cnt_q, ex_cnt_d;

    // Counter increments; they wrap naturally at 32 bits
    always_comb begin
        id_cnt_d = id_stall ? id_cnt_q + 32'd1 : id_cnt_q;
        ex_cnt_d = ex_stall ? ex_cnt_q + 32'd1 : ex_cnt_q;
    end

    // Stall counters, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_cnt_q <= 32'd0;
            ex_cnt_q <= 32'd0;
        end else begin
            id_cnt_q <= id_cnt_d;
            ex_cnt_q <= ex_cnt_d;
        end
    end

    assign IDStallCount = id_cnt_q;
    assign EXStallCount = ex_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_regs.sv
// Bench for pipeline_hazard_regs: directed hazard scenarios, then random
// traffic, all against a stage-level model that tracks whole instructions.
module tb_pipeline_hazard_regs;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_pass = 0;

  pipeline_hazard_regs_if bus();

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] id_cnt, ex_cnt;
  logic [31:0] m_idc, m_exc;
`endif

  pipeline_hazard_regs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef HAZARD_STALL_COUNT_EN
    ,
    .IDStallCount (id_cnt),
    .EXStallCount (ex_cnt)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model: each stage holds a whole instruction word or is empty
  typedef struct {
    logic        v;
    logic [31:0] ins;
  } stg_t;

  stg_t m_id, m_ex, m_mem;
  localparam stg_t EMPTY = '{v: 1'b0, ins: 32'd0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] op_of(input stg_t s);
    return s.v ? {26'd0, s.ins[31:26]} : 32'h3F;
  endfunction

  function automatic logic [31:0] fld(input stg_t s, input int lsb);
    logic [31:0] sh;
    sh = s.ins >> lsb;
    return s.v ? {27'd0, sh[4:0]} : 32'd0;
  endfunction

  task automatic model_reset();
    m_id = EMPTY; m_ex = EMPTY; m_mem = EMPTY;
`ifdef HAZARD_STALL_COUNT_EN
    m_idc = 0; m_exc = 0;
`endif
  endtask

  // advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    if (bus.EXStall) begin
      m_mem = EMPTY;
`ifdef HAZARD_STALL_COUNT_EN
      m_exc++;
`endif
    end else if (bus.IDStall) begin
      m_mem = m_ex;
      m_ex  = EMPTY;
`ifdef HAZARD_STALL_COUNT_EN
      m_idc++;
`endif
    end else begin
      m_mem = m_ex;
      m_ex  = m_id;
      if (bus.flush || !bus.IFvalid) m_id = EMPTY;
      else m_id = '{v: 1'b1, ins: bus.IFinstr};
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".IDop"},  {26'd0, bus.IDop},  op_of(m_id));
    check({tag, ".IDrm"},  {27'd0, bus.IDrm},  fld(m_id, 21));
    check({tag, ".IDrn"},  {27'd0, bus.IDrn},  fld(m_id, 16));
    check({tag, ".EXop"},  {26'd0, bus.EXop},  op_of(m_ex));
    check({tag, ".EXrp"},  {27'd0, bus.EXrp},  fld(m_ex, 11));
    check({tag, ".EXrm"},  {27'd0, bus.EXrm},  fld(m_ex, 21));
    check({tag, ".EXrn"},  {27'd0, bus.EXrn},  fld(m_ex, 16));
    check({tag, ".MEMop"}, {26'd0, bus.MEMop}, op_of(m_mem));
    check({tag, ".MEMrn"}, {27'd0, bus.MEMrn}, fld(m_mem, 16));
`ifdef HAZARD_STALL_COUNT_EN
    check({tag, ".IDcnt"}, id_cnt, m_idc);
    check({tag, ".EXcnt"}, ex_cnt, m_exc);
`endif
  endtask

  // driver: apply inputs at negedge, check PCwrite, take the edge, check stages
  task automatic drive(input string tag, input logic [31:0] ins, input logic v,
                       input logic f, input logic ids, input logic exs);
    @(negedge clk);
    bus.IFinstr = ins;
    bus.IFvalid = v;
    bus.flush   = f;
    bus.IDStall = ids;
    bus.EXStall = exs;
    #1;
    check({tag, ".PCwrite"}, {31'd0, bus.PCwrite}, {31'd0, ~(ids | exs)});
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.IFinstr = 32'd0;
    bus.IFvalid = 1'b0;
    bus.flush   = 1'b0;
    bus.IDStall = 1'b0;
    bus.EXStall = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    #1;
    check_all("reset");
    check("reset.PCwrite", {31'd0, bus.PCwrite}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // lw $5,0($2) walking through the stages
    drive("lw1", 32'h8C450000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lw1.IDop_lit", {26'd0, bus.IDop}, 32'h23);
    check("lw1.IDrm_lit", {27'd0, bus.IDrm}, 32'd2);
    check("lw1.IDrn_lit", {27'd0, bus.IDrn}, 32'd5);
    // add $6,$5,$7 follows; load-use then appears with lw in EX
    drive("add", 32'h00A73020, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lw2.EXop_lit", {26'd0, bus.EXop}, 32'h23);
    check("lw2.EXrn_lit", {27'd0, bus.EXrn}, 32'd5);
    drive("lu_stall", 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1);
    check("lu.EXop_lit",  {26'd0, bus.EXop},  32'h23);
    check("lu.MEMop_lit", {26'd0, bus.MEMop}, 32'h3F);
    drive("lu_go", 32'h10A60004, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_go.MEMop_lit", {26'd0, bus.MEMop}, 32'h23);
    check("lu_go.EXop_lit",  {26'd0, bus.EXop},  32'h00);
    check("lu_go.EXrp_lit",  {27'd0, bus.EXrp},  32'd6);

    // beq in ID waits two edges for its operands
    drive("br1", 32'hAAAAAAAA, 1'b1, 1'b0, 1'b1, 1'b0);
    check("br1.IDop_lit", {26'd0, bus.IDop}, 32'h04);
    check("br1.EXop_lit", {26'd0, bus.EXop}, 32'h3F);
    check("br1.MEMop_lit", {26'd0, bus.MEMop}, 32'h00);
    drive("br2", 32'hBBBBBBBB, 1'b1, 1'b0, 1'b1, 1'b0);
    check("br2.IDop_lit", {26'd0, bus.IDop}, 32'h04);
    check("br2.EXop_lit", {26'd0, bus.EXop}, 32'h3F);

    // flush squashes IF; with a stall the flush is ignored
    drive("flush", 32'h20010001, 1'b1, 1'b1, 1'b0, 1'b0);
    check("flush.IDop_lit", {26'd0, bus.IDop}, 32'h3F);
    drive("addi", 32'h20010001, 1'b1, 1'b0, 1'b0, 1'b0);
    drive("flush_st", 32'h8C450000, 1'b1, 1'b1, 1'b1, 1'b0);
    check("flush_st.IDop_lit", {26'd0, bus.IDop}, 32'h08);

    // both stalls: EX rule applies
    drive("both", 32'h00A73020, 1'b1, 1'b0, 1'b0, 1'b0);
    drive("both2", 32'h00A73020, 1'b1, 1'b0, 1'b0, 1'b0);
    drive("both_st", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b1);
    check("both_st.MEMop_lit", {26'd0, bus.MEMop}, 32'h3F);

    // reset in the middle of a 3-cycle load-use stall
    drive("rs_st1", 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b1);
    drive("rs_st2", 32'h22222222, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rs_mid");
    check("rs_mid.PCwrite", {31'd0, bus.PCwrite}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.EXStall = 1'b0;
    bus.IDStall = 1'b0;
    bus.flush   = 1'b0;
    bus.IFinstr = 32'h20010001;
    bus.IFvalid = 1'b1;
    #1;
    check("rs_rel.PCwrite", {31'd0, bus.PCwrite}, 32'd1);
    @(posedge clk);
    model_edge();
    #1;
    check_all("rs_first");
    check("rs_first.IDop_lit", {26'd0, bus.IDop}, 32'h08);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive("rand", $urandom, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_regs.md
Name: pipeline_hazard_regs

Overview:
- Pipeline-register bank that holds the opcode and register fields of the instructions in ID, EX and MEM.
- It feeds those fields to StallDetection and consumes its IDStall/EXStall outputs.
- It freezes the PC and the upstream registers and injects bubbles so that the 5-stage CPU resolves branch-operand and load-use hazards.
- It sits between the fetch unit (PC/instruction memory) and StallDetection/forwarding.

Parameters:
- BUBBLE_OP, 6'b111111, opcode driven for an empty (bubble) stage. It is an unused encoding, so StallDetection never matches it.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- IFinstr  input  32  instruction fetched this cycle
- IFvalid  input  1  IFinstr is a real instruction
- flush  input  1  branch/jump taken in ID; squash the instruction in IF
- IDStall  input  1  from StallDetection
- EXStall  input  1  from StallDetection
- PCwrite  output  1  PC update enable
- IDop  output  6  ID opcode (instr[31:26])
- IDrm  output  5  ID rs (instr[25:21])
- IDrn  output  5  ID rt (instr[20:16])
- EXop  output  6  EX opcode
- EXrp  output  5  EX rd (instr[15:11])
- EXrm  output  5  EX rs
- EXrn  output  5  EX rt
- MEMop  output  6  MEM opcode
- MEMrn  output  5  MEM rt

Behaviour:
- Internal state: IF/ID {instr, valid}, ID/EX {op, rs, rt, rd, valid}, EX/MEM {op, rt, valid}.
- Asynchronous reset: all valid bits 0, all fields 0.
- Output gating: an invalid stage drives op = BUBBLE_OP and all register fields 5'b00000. Outputs are combinational from the stage registers.
- PCwrite is combinational: PCwrite = ~(IDStall | EXStall). After reset it is 1.
- Normal advance (no stall): every edge does IF/ID <= {IFinstr, IFvalid}, ID/EX <= IF/ID, EX/MEM <= ID/EX. Latency from IF to ID outputs is 1 edge, to EX is 2 edges, to MEM is 3 edges.
- EXStall = 1 (load-use in EX; dominates IDStall):
  - IF/ID and ID/EX hold.
  - EX/MEM <= bubble (valid 0).
  - PCwrite = 0.
- IDStall = 1 and EXStall = 0 (branch operand not ready):
  - IF/ID holds.
  - ID/EX <= bubble.
  - EX/MEM advances from ID/EX.
  - PCwrite = 0.
- flush = 1 with no stall: IF/ID <= bubble, regardless of IFvalid. ID/EX and EX/MEM advance normally.
- flush together with any stall: the stall wins and flush is ignored, because the branch in ID has not resolved.
- IFvalid = 0 with no stall: the bubble enters IF/ID.
- Repeated stalls may last any number of cycles. The held contents must be bit-identical for the whole stall.
- Reset asserted mid-stall: all stages go invalid immediately. The first edge after deassertion loads IFinstr normally.
- No combinational path from IFinstr to any ID/EX/MEM output.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- When defined, two extra output ports are added:
  - IDStallCount[31:0]: increments on every edge where IDStall & ~EXStall.
  - EXStallCount[31:0]: increments on every edge where EXStall.
- Both counters are cleared by reset and wrap from 32'hFFFFFFFF to 0.
- When not defined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then IFvalid=1, IFinstr=32'h8C450000 (lw $5,0($2)) for 1 cycle, stalls 0 -> after edge 1: IDop=6'b100011, IDrm=2, IDrn=5. After edge 2: EXop=LW, EXrn=5. After edge 3: MEMop=LW, MEMrn=5. Bubble stages show op=6'h3F.
- Load-use: EX holds lw $5, ID holds add $6,$5,$7 (32'h00A73020), EXStall=1 for 1 edge -> ID/EX unchanged (EXop=LW), MEMop=6'h3F, PCwrite=0 during the stall. Next edge with EXStall=0 -> MEMop=LW, EXop=RTYPE, EXrp=6.
- Branch stall: ID holds beq $5,$6 (32'h10A60004), IDStall=1 for 2 edges -> IDop stays BEQ for both edges, EXop=6'h3F after each edge, the prior EX instruction moves to MEM, PCwrite=0.
- flush=1 with no stall and IFinstr=32'h20010001 -> after edge: IDop=6'h3F. Repeat with IDStall=1 -> IF/ID holds its prior contents.
- IDStall=1 and EXStall=1 together -> EX-stall rule applies: ID/EX held, MEM bubble. With HAZARD_STALL_COUNT_EN: EXStallCount increments by 1 and IDStallCount does not.
- Assert reset during a 3-cycle EXStall -> all ops read 6'h3F and all fields read 0 immediately, PCwrite=1 once the stalls drop.
